// File: rtl/mac_pkg.sv
// Shared arithmetic-datapath definitions for the mac block and its
// downstream acc_divider normaliser.
package mac_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/acc_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
    parameter int unsigned DIVISOR_W = mac_pkg::DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   pr,
    input  logic                 din,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_next,
    output logic                 qbit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] divisor_ext;

    // pr stays below divisor, so its top bit is zero in normal operation;
    // folding it into qbit keeps the step correct even if that ever breaks.
    always_comb begin
        shifted     = {pr[DIVISOR_W-1:0], din};
        divisor_ext = {1'b0, divisor};
        qbit        = pr[DIVISOR_W] | (shifted >= divisor_ext);
        pr_next     = qbit ? (shifted - divisor_ext) : shifted;
    end

endmodule

// File: rtl/acc_divider.sv
// Sequential restoring divider normalising the accumulated mac result;
// one quotient bit per clock, valid/ready on both sides.
module acc_divider #(
    parameter int unsigned DIVIDEND_W = mac_pkg::DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = mac_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    mac_pkg::div_state_t state, state_d;

    logic [DIVIDEND_W-1:0] sr, sr_d;
    logic [DIVISOR_W-1:0]  dvsr, dvsr_d;
    logic [DIVISOR_W:0]    pr, pr_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  out_valid_d;
    logic [DIVIDEND_W-1:0] quotient_d;
    logic [DIVISOR_W-1:0]  remainder_d;
    logic                  div_by_zero_d;

    logic [DIVISOR_W:0]    step_pr;
    logic                  step_q;
    logic [DIVIDEND_W-1:0] sr_shift;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .pr      (pr),
        .din     (sr[DIVIDEND_W-1]),
        .divisor (dvsr),
        .pr_next (step_pr),
        .qbit    (step_q)
    );

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign sr_shift = {sr[DIVIDEND_W-2:0], step_q};
    assign in_ready = (state == mac_pkg::IDLE);

    // Next-state and datapath update.
    always_comb begin
        state_d       = state;
        sr_d          = sr;
        dvsr_d        = dvsr;
        pr_d          = pr;
        cnt_d         = cnt;
        out_valid_d   = out_valid;
        quotient_d    = quotient;
        remainder_d   = remainder;
        div_by_zero_d = div_by_zero;

        case (state)
            mac_pkg::IDLE: begin
                if (in_valid) begin
                    sr_d   = dividend;
                    dvsr_d = divisor;
                    pr_d   = '0;
                    cnt_d  = CNT_W'(DIVIDEND_W - 1);
                    if (divisor == '0) begin
                        state_d       = mac_pkg::DONE;
                        quotient_d    = '1;
                        remainder_d   = '0;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = mac_pkg::BUSY;
                    end
                end
            end

            mac_pkg::BUSY: begin
                sr_d  = sr_shift;
                pr_d  = step_pr;
                cnt_d = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    state_d       = mac_pkg::DONE;
                    out_valid_d   = 1'b1;
                    quotient_d    = sr_shift;
                    remainder_d   = step_pr[DIVISOR_W-1:0];
                    div_by_zero_d = 1'b0;
                end
            end

            mac_pkg::DONE: begin
                // Divide-by-zero enters DONE straight from IDLE; present it one edge later.
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = mac_pkg::IDLE;
                end
            end

            default: begin
                state_d     = mac_pkg::IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= mac_pkg::IDLE;
            sr          <= '0;
            dvsr        <= '0;
            pr          <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            sr          <= sr_d;
            dvsr        <= dvsr_d;
            pr          <= pr_d;
            cnt         <= cnt_d;
            out_valid   <= out_valid_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_acc_divider.sv
// Scoreboard bench for acc_divider: driver pushes model results, monitor
// compares whenever out_valid is presented.
module tb_acc_divider;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    typedef struct {
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          dz;
        int            lat;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   seen   = 0;
    bit   post_hs = 0;

    acc_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare presented results against the front of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                seen    = 0;
                post_hs = 0;
            end else begin
                if (post_hs) begin
                    chk("post_handshake_out_valid", 32'(out_valid), 32'd0);
                    chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
                    post_hs = 0;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
                    end else begin
                        e = exp_q[0];
                        if (!seen) begin
                            chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                            seen = 1;
                        end
                        chk("quotient", 32'(quotient), 32'(e.q));
                        chk("remainder", 32'(remainder), 32'(e.r));
                        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                        chk("in_ready_while_valid", 32'(in_ready), 32'd0);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            seen    = 0;
                            post_hs = 1;
                        end
                    end
                end
            end
        end
    end

    // Present one operation, wait for acceptance and push the reference result.
    task automatic issue(input logic [DW-1:0] a, input logic [SW-1:0] b);
        exp_t e;
        bit   ok;
        ok = 0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end else begin
            if (b == 0) begin
                e.q   = '1;
                e.r   = '0;
                e.dz  = 1'b1;
                e.lat = 1;
            end else begin
                e.q   = DW'(int'(a) / int'(b));
                e.r   = SW'(int'(a) % int'(b));
                e.dz  = 1'b0;
                e.lat = DW;
            end
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input bit rand_ready);
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0) done = 1;
        end
        out_ready = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    int a_tab [8] = '{70, 1000, 5, 65535, 1234, 0, 77, 255};
    int b_tab [8] = '{7,  3,    9, 255,   0,    5, 1,  16};

    initial begin : driver
        bit got;
        logic [SW-1:0] b;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(DW'(a_tab[i]), SW'(b_tab[i]));
            drain(1'b0);
        end

        // Backpressure: hold the result for five cycles before accepting it.
        out_ready = 1'b0;
        issue(16'd42, 8'd4);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk("backpressure_out_valid_seen", 32'(got), 32'd1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        drain(1'b0);

        // New requests while busy must be ignored.
        issue(16'd200, 8'd7);
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd10;
        for (int i = 0; i < 5; i++) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain(1'b0);

        // Reset in the middle of an operation discards it.
        issue(16'd500, 8'd3);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_quotient", 32'(quotient), 32'd0);
        chk("midreset_remainder", 32'(remainder), 32'd0);
        chk("midreset_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("after_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (25) @(negedge clk);
        issue(16'd6, 8'd3);
        drain(1'b0);

        // Randomised operations with random backpressure.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = 8'd1;
                2:       b = 8'd255;
                default: b = SW'($urandom);
            endcase
            out_ready = 1'($urandom_range(0, 1));
            issue(DW'($urandom), b);
            drain(1'b1);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
